// File: rtl/reg_scoreboard.sv
// Decode-stage issue scoreboard: per-register and condition-code pending-write counters,
// ready/valid issue gating and a RUN/BRANCH/DRAIN sequencer. Optional macro: SCB_WB_BYPASS_EN.
module reg_scoreboard #(
    parameter int NUM_RF    = 16,
    parameter int IDX_WIDTH = 4,
    parameter int CNT_WIDTH = 2
) (
    input  logic                 I_CLOCK,
    input  logic                 I_RESET_N,
    input  logic                 I_IssueValid,
    input  logic                 I_Src1Use,
    input  logic [IDX_WIDTH-1:0] I_Src1Idx,
    input  logic                 I_Src2Use,
    input  logic [IDX_WIDTH-1:0] I_Src2Idx,
    input  logic                 I_DestWrite,
    input  logic [IDX_WIDTH-1:0] I_DestIdx,
    input  logic                 I_SetsCC,
    input  logic                 I_IsBranch,
    input  logic                 I_BranchDone,
    input  logic                 I_WBValid,
    input  logic [IDX_WIDTH-1:0] I_WBIdx,
    input  logic                 I_WBSetsCC,
    input  logic                 I_DrainReq,
    output logic                 O_IssueReady,
    output logic                 O_DepStall,
    output logic                 O_BranchStall,
    output logic                 O_DrainDone,
    output logic [NUM_RF-1:0]    O_PendingMask,
    output logic                 O_CCValid,
    output logic                 O_Underflow
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_BRANCH,
        ST_DRAIN
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t state, state_next;

    logic [NUM_RF-1:0][CNT_WIDTH-1:0] cnt, cnt_next;
    logic [CNT_WIDTH-1:0]             cc_cnt, cc_next;
    logic                             underflow, underflow_next;
    logic [NUM_RF-1:0]                pend_mask, pend_mask_next;
    logic                             cc_valid;

    logic clr_src1, clr_src2, clr_cc;
    logic haz_src1, haz_src2, haz_dest, haz_cc, hazard;
    logic run, fire, drain_done, all_zero_next;
    logic cc_inc, cc_dec;

`ifdef SCB_WB_BYPASS_EN
    assign clr_src1 = I_WBValid && (I_WBIdx == I_Src1Idx) && (cnt[I_Src1Idx] == CNT_ONE);
    assign clr_src2 = I_WBValid && (I_WBIdx == I_Src2Idx) && (cnt[I_Src2Idx] == CNT_ONE);
    assign clr_cc   = I_WBValid && I_WBSetsCC && (cc_cnt == CNT_ONE);
`else
    assign clr_src1 = 1'b0;
    assign clr_src2 = 1'b0;
    assign clr_cc   = 1'b0;
`endif

    assign haz_src1 = I_Src1Use && (cnt[I_Src1Idx] != '0) && !clr_src1;
    assign haz_src2 = I_Src2Use && (cnt[I_Src2Idx] != '0) && !clr_src2;
    // A saturated destination may still issue when that register retires this cycle (net zero).
    assign haz_dest = I_DestWrite && (cnt[I_DestIdx] == CNT_MAX)
                      && !(I_WBValid && (I_WBIdx == I_DestIdx));
    assign haz_cc   = I_IsBranch && (cc_cnt != '0) && !clr_cc;
    assign hazard   = haz_src1 || haz_src2 || haz_dest || haz_cc;

    assign run           = (state == ST_RUN);
    assign O_IssueReady  = run && !hazard;
    assign O_DepStall    = I_IssueValid && run && hazard;
    assign O_BranchStall = (state == ST_BRANCH);
    assign fire          = I_IssueValid && O_IssueReady;

    assign cc_inc = fire && I_SetsCC;
    assign cc_dec = I_WBValid && I_WBSetsCC;

    always_comb begin
        cnt_next       = cnt;
        cc_next        = cc_cnt;
        underflow_next = underflow;
        for (int unsigned i = 0; i < NUM_RF; i++) begin
            if (fire && I_DestWrite && (I_DestIdx == IDX_WIDTH'(i))
                && !(I_WBValid && (I_WBIdx == IDX_WIDTH'(i)))) begin
                cnt_next[i] = cnt[i] + CNT_ONE;
            end else if (I_WBValid && (I_WBIdx == IDX_WIDTH'(i))
                         && !(fire && I_DestWrite && (I_DestIdx == IDX_WIDTH'(i)))) begin
                if (cnt[i] == '0) begin
                    underflow_next = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] - CNT_ONE;
                end
            end
        end
        if (cc_inc && !cc_dec) begin
            if (cc_cnt != CNT_MAX) begin
                cc_next = cc_cnt + CNT_ONE;
            end
        end else if (cc_dec && !cc_inc) begin
            if (cc_cnt == '0) begin
                underflow_next = 1'b1;
            end else begin
                cc_next = cc_cnt - CNT_ONE;
            end
        end
    end

    assign all_zero_next = (cnt_next == '0) && (cc_next == '0);

    always_comb begin
        pend_mask_next = '0;
        for (int unsigned i = 0; i < NUM_RF; i++) begin
            pend_mask_next[i] = (cnt_next[i] != '0);
        end
    end

    always_comb begin
        state_next = state;
        drain_done = 1'b0;
        case (state)
            ST_RUN: begin
                if (fire && I_IsBranch) begin
                    state_next = ST_BRANCH;
                end else if (I_DrainReq) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_BRANCH: begin
                if (I_BranchDone) begin
                    state_next = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (all_zero_next) begin
                    drain_done = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge I_CLOCK) begin
        if (!I_RESET_N) begin
            state     <= ST_RUN;
            cnt       <= '0;
            cc_cnt    <= '0;
            underflow <= 1'b0;
            pend_mask <= '0;
            cc_valid  <= 1'b1;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            cc_cnt    <= cc_next;
            underflow <= underflow_next;
            pend_mask <= pend_mask_next;
            cc_valid  <= (cc_next == '0);
        end
    end

    assign O_DrainDone   = drain_done;
    assign O_PendingMask = pend_mask;
    assign O_CCValid     = cc_valid;
    assign O_Underflow   = underflow;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vector table, hand-written corner sequences,
// and randomized traffic against a counter-array reference model.
module tb_reg_scoreboard;

    localparam int NUM_RF = 16;
    localparam int MAXC   = 3;
`ifdef SCB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        I_CLOCK = 1'b0;
    logic        I_RESET_N;
    logic        I_IssueValid, I_Src1Use, I_Src2Use, I_DestWrite;
    logic [3:0]  I_Src1Idx, I_Src2Idx, I_DestIdx, I_WBIdx;
    logic        I_SetsCC, I_IsBranch, I_BranchDone, I_WBValid, I_WBSetsCC, I_DrainReq;
    logic        O_IssueReady, O_DepStall, O_BranchStall, O_DrainDone, O_CCValid, O_Underflow;
    logic [15:0] O_PendingMask;

    int n_pass = 0;
    int n_total = 0;

    always #5 I_CLOCK = ~I_CLOCK;

    reg_scoreboard #(.NUM_RF(16), .IDX_WIDTH(4), .CNT_WIDTH(2)) dut (
        .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_IssueValid(I_IssueValid),
        .I_Src1Use(I_Src1Use), .I_Src1Idx(I_Src1Idx), .I_Src2Use(I_Src2Use), .I_Src2Idx(I_Src2Idx),
        .I_DestWrite(I_DestWrite), .I_DestIdx(I_DestIdx), .I_SetsCC(I_SetsCC),
        .I_IsBranch(I_IsBranch), .I_BranchDone(I_BranchDone), .I_WBValid(I_WBValid),
        .I_WBIdx(I_WBIdx), .I_WBSetsCC(I_WBSetsCC), .I_DrainReq(I_DrainReq),
        .O_IssueReady(O_IssueReady), .O_DepStall(O_DepStall), .O_BranchStall(O_BranchStall),
        .O_DrainDone(O_DrainDone), .O_PendingMask(O_PendingMask), .O_CCValid(O_CCValid),
        .O_Underflow(O_Underflow)
    );

    typedef struct {
        logic       valid, s1u; logic [3:0] s1; logic s2u; logic [3:0] s2;
        logic       dw; logic [3:0] d; logic setcc, isbr, bdone, wbv; logic [3:0] wbi;
        logic       wbcc, drain;
        logic       e_ready, e_dep, e_bst, e_dd; logic [15:0] e_mask; logic e_ccv, e_uf;
    } vec_t;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clr_in();
        I_IssueValid = 0; I_Src1Use = 0; I_Src1Idx = 0; I_Src2Use = 0; I_Src2Idx = 0;
        I_DestWrite = 0; I_DestIdx = 0; I_SetsCC = 0; I_IsBranch = 0; I_BranchDone = 0;
        I_WBValid = 0; I_WBIdx = 0; I_WBSetsCC = 0; I_DrainReq = 0;
    endtask

    // Reference model: plain integer pending counts and a bench-local mode number.
    localparam int M_RUN = 0, M_BR = 1, M_DR = 2;
    int m_cnt[NUM_RF]; int m_cc; int m_mode; bit m_uf;
    int n_cnt[NUM_RF]; int n_cc; int n_mode; bit n_uf;
    bit e_ready, e_dep, e_bst, e_dd;

    task automatic model_reset();
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_cc = 0; m_mode = M_RUN; m_uf = 0;
    endtask

    task automatic model_eval();
        bit haz, fire; int tot;
        haz = 0;
        if (I_Src1Use && m_cnt[I_Src1Idx] > 0
            && !(BYP && I_WBValid && I_WBIdx == I_Src1Idx && m_cnt[I_Src1Idx] == 1)) haz = 1;
        if (I_Src2Use && m_cnt[I_Src2Idx] > 0
            && !(BYP && I_WBValid && I_WBIdx == I_Src2Idx && m_cnt[I_Src2Idx] == 1)) haz = 1;
        if (I_DestWrite && m_cnt[I_DestIdx] == MAXC && !(I_WBValid && I_WBIdx == I_DestIdx)) haz = 1;
        if (I_IsBranch && m_cc > 0 && !(BYP && I_WBValid && I_WBSetsCC && m_cc == 1)) haz = 1;
        e_ready = (m_mode == M_RUN) && !haz;
        e_dep   = I_IssueValid && (m_mode == M_RUN) && haz;
        e_bst   = (m_mode == M_BR);
        fire    = I_IssueValid && e_ready;
        n_cnt = m_cnt; n_cc = m_cc; n_uf = m_uf;
        if (fire && I_DestWrite) n_cnt[I_DestIdx] += 1;
        if (I_WBValid) n_cnt[I_WBIdx] -= 1;
        if (fire && I_SetsCC) n_cc += 1;
        if (I_WBValid && I_WBSetsCC) n_cc -= 1;
        tot = 0;
        foreach (n_cnt[r]) begin
            if (n_cnt[r] < 0) begin n_cnt[r] = 0; n_uf = 1; end
            if (n_cnt[r] > MAXC) n_cnt[r] = MAXC;
            tot += n_cnt[r];
        end
        if (n_cc < 0) begin n_cc = 0; n_uf = 1; end
        if (n_cc > MAXC) n_cc = MAXC;
        tot += n_cc;
        e_dd = (m_mode == M_DR) && (tot == 0);
        n_mode = m_mode;
        if (m_mode == M_RUN) begin
            if (fire && I_IsBranch) n_mode = M_BR;
            else if (I_DrainReq) n_mode = M_DR;
        end else if (m_mode == M_BR) begin
            if (I_BranchDone) n_mode = M_RUN;
        end else if (e_dd) begin
            n_mode = M_RUN;
        end
    endtask

    function automatic logic [15:0] model_mask();
        logic [15:0] m = '0;
        foreach (m_cnt[r]) m[r] = (m_cnt[r] != 0);
        return m;
    endfunction

    task automatic do_reset();
        clr_in();
        I_RESET_N = 0;
        @(posedge I_CLOCK); #1;
        I_RESET_N = 1;
        model_reset();
        #2;
        chk16("rst_mask", O_PendingMask, 16'h0000);
        chk1("rst_ccvalid", O_CCValid, 1'b1);
        chk1("rst_underflow", O_Underflow, 1'b0);
        chk1("rst_drain_done", O_DrainDone, 1'b0);
        chk1("rst_branch_stall", O_BranchStall, 1'b0);
        chk1("rst_ready", O_IssueReady, 1'b1);
    endtask

    function automatic vec_t mk(input logic valid, s1u, input logic [3:0] s1, input logic s2u,
                                input logic [3:0] s2, input logic dw, input logic [3:0] d,
                                input logic setcc, isbr, bdone, wbv, input logic [3:0] wbi,
                                input logic wbcc, drain, e_ready, e_dep, e_bst, e_dd,
                                input logic [15:0] e_mask, input logic e_ccv, e_uf);
        vec_t v;
        v.valid = valid; v.s1u = s1u; v.s1 = s1; v.s2u = s2u; v.s2 = s2; v.dw = dw; v.d = d;
        v.setcc = setcc; v.isbr = isbr; v.bdone = bdone; v.wbv = wbv; v.wbi = wbi;
        v.wbcc = wbcc; v.drain = drain; v.e_ready = e_ready; v.e_dep = e_dep; v.e_bst = e_bst;
        v.e_dd = e_dd; v.e_mask = e_mask; v.e_ccv = e_ccv; v.e_uf = e_uf;
        return v;
    endfunction

    // One cycle with the current inputs: combinational checks mid-cycle, registered after the edge.
    task automatic model_cycle(input string tag);
        #2;
        model_eval();
        chk1({tag, "_ready"}, O_IssueReady, e_ready);
        chk1({tag, "_depstall"}, O_DepStall, e_dep);
        chk1({tag, "_bstall"}, O_BranchStall, e_bst);
        chk1({tag, "_ddone"}, O_DrainDone, e_dd);
        @(posedge I_CLOCK); #1;
        m_cnt = n_cnt; m_cc = n_cc; m_mode = n_mode; m_uf = n_uf;
        chk16({tag, "_mask"}, O_PendingMask, model_mask());
        chk1({tag, "_ccvalid"}, O_CCValid, m_cc == 0);
        chk1({tag, "_underflow"}, O_Underflow, m_uf);
    endtask

    vec_t tbl[$];

    initial begin
        I_RESET_N = 0;
        clr_in();
        repeat (2) @(posedge I_CLOCK);
        #1;

        //        vl s1u s1 s2u s2 dw d  cc br bd wb wi wcc dr | rdy dep bst dd mask      ccv uf
        tbl.push_back(mk(1, 1, 1, 1, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0008, 1, 0));
        tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 16'h0008, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0,  1, 0, 0, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0020, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0020, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0020, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 16'h0020, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 5, 0, 0,  1, 0, 0, 0, 16'h0020, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0,  1, 0, 0, 0, 16'h0020, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0,  1, 0, 0, 0, 16'h0020, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0,  1, 0, 0, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0040, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 16'h0040, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 1, 0,  1, 0, 0, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0002, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 16'h0006, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 16'h0006, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1,  0, 0, 0, 0, 16'h0004, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1,  0, 0, 0, 1, 16'h0000, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0,  1, 0, 0, 0, 16'h0000, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 1, 1));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            I_IssueValid = v.valid; I_Src1Use = v.s1u; I_Src1Idx = v.s1; I_Src2Use = v.s2u;
            I_Src2Idx = v.s2; I_DestWrite = v.dw; I_DestIdx = v.d; I_SetsCC = v.setcc;
            I_IsBranch = v.isbr; I_BranchDone = v.bdone; I_WBValid = v.wbv; I_WBIdx = v.wbi;
            I_WBSetsCC = v.wbcc; I_DrainReq = v.drain;
            #2;
            chk1($sformatf("row%0d_ready", i), O_IssueReady, v.e_ready);
            chk1($sformatf("row%0d_depstall", i), O_DepStall, v.e_dep);
            chk1($sformatf("row%0d_bstall", i), O_BranchStall, v.e_bst);
            chk1($sformatf("row%0d_ddone", i), O_DrainDone, v.e_dd);
            @(posedge I_CLOCK); #1;
            chk16($sformatf("row%0d_mask", i), O_PendingMask, v.e_mask);
            chk1($sformatf("row%0d_ccvalid", i), O_CCValid, v.e_ccv);
            chk1($sformatf("row%0d_underflow", i), O_Underflow, v.e_uf);
        end

        // Register writeback bypass: dependent read in the retire cycle.
        do_reset();
        clr_in(); I_IssueValid = 1; I_DestWrite = 1; I_DestIdx = 3;
        #2; chk1("byp_issue_ready", O_IssueReady, 1'b1);
        @(posedge I_CLOCK); #1;
        clr_in(); I_IssueValid = 1; I_Src1Use = 1; I_Src1Idx = 3; I_WBValid = 1; I_WBIdx = 3;
        #2;
        chk1("byp_src_ready", O_IssueReady, BYP);
        chk1("byp_src_depstall", O_DepStall, !BYP);
        @(posedge I_CLOCK); #1;
        chk16("byp_src_mask", O_PendingMask, 16'h0000);
        clr_in(); I_IssueValid = 1; I_Src1Use = 1; I_Src1Idx = 3;
        #2; chk1("byp_src_next_ready", O_IssueReady, 1'b1);
        @(posedge I_CLOCK); #1;

        // Condition-code bypass: branch in the cycle its CC producer retires.
        clr_in(); I_IssueValid = 1; I_DestWrite = 1; I_DestIdx = 6; I_SetsCC = 1;
        @(posedge I_CLOCK); #1;
        chk1("byp_cc_ccvalid", O_CCValid, 1'b0);
        clr_in(); I_IssueValid = 1; I_IsBranch = 1; I_WBValid = 1; I_WBIdx = 6; I_WBSetsCC = 1;
        #2;
        chk1("byp_cc_ready", O_IssueReady, BYP);
        @(posedge I_CLOCK); #1;
        chk1("byp_cc_ccvalid2", O_CCValid, 1'b1);
        chk1("byp_cc_bstall", O_BranchStall, BYP);

        // Reset while in BRANCH with sticky underflow and pending CC.
        do_reset();
        clr_in(); I_IssueValid = 1; I_IsBranch = 1; I_SetsCC = 1; I_DestWrite = 1; I_DestIdx = 4;
        #2; chk1("rb_branch_ready", O_IssueReady, 1'b1);
        @(posedge I_CLOCK); #1;
        clr_in(); I_WBValid = 1; I_WBIdx = 9;
        #2; chk1("rb_bstall", O_BranchStall, 1'b1);
        @(posedge I_CLOCK); #1;
        chk1("rb_uf_set", O_Underflow, 1'b1);
        chk1("rb_cc_pending", O_CCValid, 1'b0);
        clr_in(); I_RESET_N = 0;
        @(posedge I_CLOCK); #1;
        I_RESET_N = 1;
        #2;
        chk1("rb_bstall_cleared", O_BranchStall, 1'b0);
        chk1("rb_uf_cleared", O_Underflow, 1'b0);
        chk1("rb_ccvalid", O_CCValid, 1'b1);
        chk16("rb_mask", O_PendingMask, 16'h0000);
        I_IssueValid = 1; I_Src1Use = 1; I_Src1Idx = 4; I_IsBranch = 1;
        #1; chk1("rb_ready_after", O_IssueReady, 1'b1);
        @(posedge I_CLOCK); #1;
        clr_in();

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int pend[$];
            clr_in();
            I_IssueValid = ($urandom_range(0, 9) < 7);
            I_Src1Use    = $urandom_range(0, 1);
            I_Src1Idx    = 4'($urandom_range(0, 7));
            I_Src2Use    = $urandom_range(0, 1);
            I_Src2Idx    = 4'($urandom_range(0, 7));
            I_DestWrite  = $urandom_range(0, 1);
            I_DestIdx    = 4'($urandom_range(0, 7));
            I_SetsCC     = ($urandom_range(0, 3) == 0);
            I_IsBranch   = ($urandom_range(0, 9) == 0);
            I_BranchDone = ($urandom_range(0, 3) == 0);
            I_DrainReq   = ($urandom_range(0, 9) == 0);
            foreach (m_cnt[r]) if (m_cnt[r] > 0) pend.push_back(r);
            if (pend.size() > 0 && $urandom_range(0, 9) < 4) begin
                I_WBValid  = 1;
                I_WBIdx    = 4'(pend[$urandom_range(0, pend.size() - 1)]);
                I_WBSetsCC = (m_cc > 0) && ($urandom_range(0, 1) == 1);
            end
            model_cycle($sformatf("rnd%0d", c));
        end

        clr_in();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Issue-control block for the decode stage: tracks in-flight writes to the scalar register file and the condition code.
- Gates instruction issue with a ready/valid handshake and raises dependency and branch stalls.
- Sequences drain requests.
- Sits between fetch/decode and execute; writeback retirements arrive from the writeback stage.

Parameters:
NUM_RF, 16, number of scalar architectural registers
IDX_WIDTH, 4, register index width (log2 NUM_RF)
CNT_WIDTH, 2, per-register pending-write counter width; max in flight per register = 2^CNT_WIDTH-1

Ports:
I_CLOCK  in  1  clock
I_RESET_N  in  1  reset, synchronous active-low
I_IssueValid  in  1  decoded instruction presented
I_Src1Use / I_Src2Use  in  1 each  source operand read enables
I_Src1Idx / I_Src2Idx  in  IDX_WIDTH each  source register indices
I_DestWrite  in  1  instruction writes a register
I_DestIdx  in  IDX_WIDTH  destination index
I_SetsCC  in  1  instruction updates condition code
I_IsBranch  in  1  conditional branch/jump; reads condition code
I_BranchDone  in  1  branch resolved by execute (1-cycle pulse)
I_WBValid  in  1  writeback retiring this cycle
I_WBIdx  in  IDX_WIDTH  retiring register
I_WBSetsCC  in  1  retiring instruction set condition code
I_DrainReq  in  1  request pipeline drain (level)
O_IssueReady  out  1  issue accepted this cycle when high with I_IssueValid
O_DepStall  out  1  I_IssueValid high and blocked by data/CC hazard
O_BranchStall  out  1  FSM in BRANCH
O_DrainDone  out  1  1-cycle pulse when drain completes
O_PendingMask  out  NUM_RF  bit i = counter i nonzero (registered)
O_CCValid  out  1  CC pending counter zero (registered)
O_Underflow  out  1  sticky: retire to zero counter

Behaviour:
- Reset (I_RESET_N low at posedge), regardless of state:
  - all counters 0, FSM RUN
  - O_PendingMask 0, O_CCValid 1, O_Underflow 0, O_DrainDone 0
  - O_IssueReady/O_DepStall/O_BranchStall are combinational from state and counters; they evaluate accordingly.
- Reset mid-BRANCH or mid-DRAIN returns to RUN and discards in-flight tracking.
- Hazard (combinational) is the OR of:
  - src1: used and count[Src1] != 0 and not clear_now(Src1)
  - src2: same rule as src1
  - dest: I_DestWrite and count[Dest] saturated and not (WB same reg this cycle)
  - CC: I_IsBranch and cc_cnt != 0 and not (I_WBValid and I_WBSetsCC and cc_cnt == 1)
- clear_now(r) = I_WBValid and I_WBIdx == r and count[r] == 1 (writeback bypass).
- O_IssueReady = state RUN and not hazard. O_DepStall = I_IssueValid and state RUN and hazard.
- Issue fire = I_IssueValid and O_IssueReady. On fire:
  - count[Dest]++ if I_DestWrite
  - cc_cnt++ if I_SetsCC
  - if I_IsBranch, next state BRANCH
- On I_WBValid:
  - count[WBIdx]--
  - cc_cnt-- if I_WBSetsCC
  - decrement of a zero counter leaves it 0 and sets O_Underflow (until reset)
- Same-cycle issue and retire to the same register (or both touching CC): counter unchanged. Counters never wrap.
- FSM:
  - RUN: on issue of branch -> BRANCH; else if I_DrainReq -> DRAIN (issue still blocked that cycle only if already in DRAIN).
  - BRANCH: no issue; on I_BranchDone -> RUN (I_DrainReq honoured next cycle).
  - DRAIN: no issue; when all counters and cc_cnt are zero after this cycle's retire, pulse O_DrainDone and -> RUN.
  - I_DrainReq in RUN with a fire in the same cycle: the fire wins if it is a branch (-> BRANCH); otherwise the issue is accepted and the FSM enters DRAIN.
- Latency:
  - issue-to-hazard visible on the next cycle
  - writeback-to-unblock is the same cycle (see optional feature)
  - O_PendingMask/O_CCValid reflect post-update counters, one cycle after the event.

Optional Feature:
SCB_WB_BYPASS_EN
- Defined: clear_now and the CC bypass term apply, so a dependent instruction issues in the same cycle its last producer retires.
- Undefined: both bypass terms are forced 0, so a dependent instruction issues one cycle after the retire. Counter update rules are unchanged.

Test Plan:
- Reset, issue ADD R3<-R1,R2 (DestWrite, Dest=3) -> O_IssueReady=1; next cycle O_PendingMask=0x0008.
- R3 pending (count 1), present Src1=3 -> O_DepStall=1, O_IssueReady=0. Same cycle I_WBValid, WBIdx=3 -> bypass on: ready=1; bypass off: ready next cycle. Either way mask bit 3 clears.
- Issue 3 writes to R5 (CNT_WIDTH=2, count=3), 4th write to R5 -> stalled. Retire R5 same cycle -> accepted, count stays 3.
- Issue SetsCC instr, then branch -> stall until WB with WBSetsCC. Branch issues -> O_BranchStall=1, next issue blocked until I_BranchDone pulse -> RUN.
- Two writes pending (R1, R2), I_DrainReq=1 -> no issue. Retire R1, then R2 -> O_DrainDone pulses on the R2 retire cycle. Next cycle RUN, O_PendingMask=0.
- Retire R7 with count 0 -> O_Underflow=1, counters unchanged. Assert I_RESET_N=0 in BRANCH -> next cycle RUN, O_Underflow=0, O_CCValid=1.
